// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and default constants for the data memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    AT_WORD   = 2'b00,
    AT_HALF_S = 2'b01,
    AT_BYTE_S = 2'b10,
    AT_BYTE_U = 2'b11
  } dmem_atype_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } dmem_state_e;

  localparam int DMEM_DEFAULT_DEPTH_WORDS = 1024;
  localparam int DMEM_DEFAULT_WAIT_CYCLES = 2;

  function automatic logic dmem_misaligned(dmem_atype_e atype, logic [1:0] byte_off);
    return ((atype == AT_WORD) && (byte_off != 2'b00)) ||
           ((atype == AT_HALF_S) && byte_off[0]);
  endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Byte-lane steering: merges store data into the addressed word and
// extracts/extends load data. Word and halfword accesses ignore the sub-aligned offset bits.
module dmem_byte_lane
  import dmem_pkg::*;
(
  input  logic [31:0] cur_word,
  input  logic [31:0] wr_data,
  input  logic [1:0]  byte_off,
  input  dmem_atype_e atype,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_half    = byte_off[1] ? cur_word[31:16] : cur_word[15:0];
    sel_byte    = cur_word[{byte_off, 3'b000} +: 8];
    merged_word = cur_word;
    load_data   = 32'h0;
    case (atype)
      AT_WORD: begin
        merged_word = wr_data;
        load_data   = cur_word;
      end
      AT_HALF_S: begin
        if (byte_off[1]) merged_word[31:16] = wr_data[15:0];
        else             merged_word[15:0]  = wr_data[15:0];
        load_data = {{16{sel_half[15]}}, sel_half};
      end
      AT_BYTE_S: begin
        merged_word[{byte_off, 3'b000} +: 8] = wr_data[7:0];
        load_data = {{24{sel_byte[7]}}, sel_byte};
      end
      default: begin
        merged_word[{byte_off, 3'b000} +: 8] = wr_data[7:0];
        load_data = {24'h0, sel_byte};
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder with a fixed wait-state count.
// Optional build macro DMEM_ALIGN_CHECK_EN: flag misaligned word/halfword accesses as errors.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting; a present request is latched and Busy is raised
// ST_WAIT    | counting wait cycles down to zero, Busy held high
// ST_RESPOND | Done pulse; store committed or load data presented
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEFAULT_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DMEM_DEFAULT_WAIT_CYCLES
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  AddressType,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int WAIT_LOAD_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0] WAIT_LOAD = WAIT_LOAD_I[3:0];

  dmem_state_e   state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  dmem_atype_e   atype_q, atype_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          is_write_q, is_write_d;
  logic          err_q, err_d;
  logic [31:0]   read_data_q, read_data_d;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0]   cur_word, merged_word, load_data;
  logic          mem_we;
  logic          align_err;
  logic          unused_addr;

  assign unused_addr = ^Address[31:AW+2];
  assign word_idx    = addr_q[AW+1:2];
  assign cur_word    = mem_q[word_idx];

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = dmem_misaligned(dmem_atype_e'(AddressType), Address[1:0]);
`else
  assign align_err = 1'b0;
`endif

  dmem_byte_lane u_byte_lane (
    .cur_word    (cur_word),
    .wr_data     (wdata_q),
    .byte_off    (addr_q[1:0]),
    .atype       (atype_q),
    .merged_word (merged_word),
    .load_data   (load_data)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    addr_d      = addr_q;
    atype_d     = atype_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    err_d       = err_q;
    read_data_d = read_data_q;
    ReadData    = read_data_q;
    Busy        = 1'b0;
    Done        = 1'b0;
    Error       = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MemRead || MemWrite) begin
          // Busy must stay low while reset is held, even with a request present.
          Busy       = Rst;
          addr_d     = Address[AW+1:0];
          atype_d    = dmem_atype_e'(AddressType);
          wdata_d    = WriteData;
          is_write_d = MemWrite;
          err_d      = (MemRead && MemWrite) || align_err;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESPOND;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        Busy = 1'b1;
        if (wait_cnt_q == 4'd0) state_d = ST_RESPOND;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      ST_RESPOND: begin
        Done    = 1'b1;
        Error   = err_q;
        state_d = ST_IDLE;
        if (err_q) begin
          ReadData    = 32'h0;
          read_data_d = 32'h0;
        end else if (is_write_q) begin
          mem_we = 1'b1;
        end else begin
          ReadData    = load_data;
          read_data_d = load_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 4'd0;
      addr_q      <= '0;
      atype_q     <= AT_WORD;
      wdata_q     <= 32'h0;
      is_write_q  <= 1'b0;
      err_q       <= 1'b0;
      read_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      atype_q     <= atype_d;
      wdata_q     <= wdata_d;
      is_write_q  <= is_write_d;
      err_q       <= err_d;
      read_data_q <= read_data_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[word_idx] <= merged_word;
  end

endmodule
